// File: rtl/div_iter_lz.sv
// Multi-cycle DIV/DIVU unit: HI=remainder, LO=quotient.
// Leading-zero counts from external CLZ blocks let it skip leading quotient bits.
module div_iter_lz #(
  parameter int DATA_W = 32,
  parameter int LZ_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] mag_a_o,
  output logic [DATA_W-1:0] mag_b_o,
  input  logic [LZ_W-1:0]   lz_a,
  input  logic [LZ_W-1:0]   lz_b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

  state_t              state, state_nx;
  logic                sign_a, sign_b, sgn, dz;
  logic [DATA_W-1:0]   rem, quo;
  logic [LZ_W-1:0]     cnt;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] t;
  logic                ge;
  logic                b_zero, early;

  always_comb begin
    abs_a  = (is_signed & a[DATA_W-1]) ? -a : a;
    abs_b  = (is_signed & b[DATA_W-1]) ? -b : b;
    t      = {rem, quo} << 1;
    ge     = t[2*DATA_W-1:DATA_W] >= mag_b_o;
    b_zero = (mag_b_o == '0);
    // |b| has more significant bits than |a| (or a is zero): quotient is 0
    early  = (lz_a > lz_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PREP;
      PREP:    state_nx = (b_zero || early) ? FIN : CALC;
      CALC:    if (cnt == LZ_W'(1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a_o  <= '0;
      mag_b_o  <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      sgn      <= 1'b0;
      dz       <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a_o <= abs_a;
            mag_b_o <= abs_b;
            sign_a  <= a[DATA_W-1];
            sign_b  <= b[DATA_W-1];
            sgn     <= is_signed;
            dz      <= 1'b0;
          end
        end
        PREP: begin
          if (b_zero) begin
            quo <= '1;
            rem <= mag_a_o;
            dz  <= 1'b1;
          end else if (early) begin
            quo <= '0;
            rem <= mag_a_o;
          end else begin
            // left-align the dividend so only its significant bits are stepped
            quo <= mag_a_o << lz_a;
            rem <= '0;
            cnt <= LZ_W'(DATA_W) - lz_a;
          end
        end
        CALC: begin
          if (ge) begin
            rem <= t[2*DATA_W-1:DATA_W] - mag_b_o;
            quo <= {t[DATA_W-1:1], 1'b1};
          end else begin
            rem <= t[2*DATA_W-1:DATA_W];
            quo <= t[DATA_W-1:0];
          end
          cnt <= cnt - LZ_W'(1);
        end
        FIN: begin
          lo       <= (sgn & (sign_a ^ sign_b) & ~dz) ? -quo : quo;
          hi       <= (sgn & sign_a) ? -rem : rem;
          done     <= 1'b1;
          div_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_lz.sv
// Self-checking bench for div_iter_lz: behavioural CLZ + divide model, directed and random ops.
module tb_div_iter_lz;

  logic        clk = 1'b0;
  logic        rst, start, is_signed;
  logic [31:0] a, b, mag_a_o, mag_b_o, hi, lo;
  logic [5:0]  lz_a, lz_b;
  logic        busy, done, div_zero;

  typedef struct {
    int unsigned scyc;
    int unsigned dcyc;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned last_done = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned done_cnt = 0;
  logic [31:0] held_lo = '0, held_hi = '0;
  logic        eb, ed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] clz(input logic [31:0] x);
    clz = 6'd32;
    for (int i = 0; i < 32; i++) if (x[i]) clz = 6'(31 - i);
  endfunction

  assign lz_a = clz(mag_a_o);
  assign lz_b = clz(mag_b_o);

  div_iter_lz #(.DATA_W(32), .LZ_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .mag_a_o(mag_a_o), .mag_b_o(mag_b_o),
    .lz_a(lz_a), .lz_b(lz_b), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                 input int unsigned sc);
    exp_t        e;
    logic [31:0] ma, mb;
    longint      sx, sy;
    int unsigned n;
    ma = (s && x[31]) ? -x : x;
    mb = (s && y[31]) ? -y : y;
    n  = 0;
    if (y == 0) begin
      e.lo = '1; e.hi = x; e.dz = 1'b1;
    end else begin
      e.dz = 1'b0;
      if (s) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.lo = 32'(sx / sy);
        e.hi = 32'(sx % sy);
      end else begin
        e.lo = x / y;
        e.hi = x % y;
      end
      n = (clz(ma) > clz(mb)) ? 0 : 32 - int'(clz(ma));
    end
    e.scyc = sc;
    e.dcyc = sc + n + 3;
    return e;
  endfunction

  // per-cycle compare of DUT against the model queue
  always @(negedge clk) begin
    eb = 1'b0;
    foreach (q[i]) if (cyc > q[i].scyc && cyc < q[i].dcyc) eb = 1'b1;
    ed = (q.size() > 0) && (q[0].dcyc == cyc);
    check("busy", {31'd0, busy}, {31'd0, eb});
    check("done", {31'd0, done}, {31'd0, ed});
    if (done) done_cnt++;
    if (ed) begin
      check("div_zero", {31'd0, div_zero}, {31'd0, q[0].dz});
      held_lo = q[0].lo;
      held_hi = q[0].hi;
      void'(q.pop_front());
    end
    check("lo", lo, held_lo);
    check("hi", hi, held_hi);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [31:0] x, input logic [31:0] y, input logic st);
    exp_t e;
    start = st; is_signed = s; a = x; b = y;
    if (st && cyc >= last_done) begin
      e = model(s, x, y, cyc);
      q.push_back(e);
      last_done = e.dcyc;
    end
  endtask

  task automatic wait_idle();
    tick();
    while (cyc < last_done) begin
      drive(1'b0, '0, '0, 1'b0);
      tick();
    end
  endtask

  task automatic directed(input string nm, input logic s, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ex_lo, input logic [31:0] ex_hi, input logic ex_dz,
                          input int unsigned lat);
    int unsigned sc;
    bit          got;
    wait_idle();
    drive(s, x, y, 1'b1);
    sc = cyc;
    tick();
    drive(1'b0, '0, '0, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check({nm, " latency"}, got ? cyc - sc : 32'hFFFF_FFFF, lat);
    check({nm, " lo"}, lo, ex_lo);
    check({nm, " hi"}, hi, ex_hi);
    check({nm, " dz"}, {31'd0, div_zero}, {31'd0, ex_dz});
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned sc, dc;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mag_a_o", mag_a_o, 32'h0);
    check("reset mag_b_o", mag_b_o, 32'h0);
    check("reset busy", {31'd0, busy}, 32'h0);
    check("reset done", {31'd0, done}, 32'h0);
    check("reset div_zero", {31'd0, div_zero}, 32'h0);
    #1 rst = 1'b0;
    last_done = cyc;

    directed("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10);
    directed("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 6);
    directed("divu 5/9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 3);
    directed("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 35);
    directed("div 0x1234/0", 1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 3);
    directed("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 35);
    directed("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 6);
    directed("divu 0/5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 3);
    directed("div -8/0", 1'b1, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1, 3);

    // reset in the middle of a 32-step op
    wait_idle();
    drive(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    sc = cyc;
    while (cyc < sc + 6) begin
      tick();
      drive(1'b0, '0, '0, 1'b0);
    end
    rst = 1'b1;
    q.delete();
    held_lo = '0; held_hi = '0;
    last_done = cyc;
    dc = done_cnt;
    tick();
    rst = 1'b0;
    repeat (45) tick();
    check("midrst busy", {31'd0, busy}, 32'h0);
    check("midrst hi", hi, 32'h0);
    check("midrst lo", lo, 32'h0);
    check("midrst no done", done_cnt - dc, 32'd0);

    // start held while busy: one accepted op only
    wait_idle();
    dc = done_cnt;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    repeat (45) tick();
    check("held start one done", done_cnt - dc, 32'd1);

    // random traffic, including back-to-back and ignored starts
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 1)), rnd_op(), rnd_op(), $urandom_range(0, 2) == 0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 100 && q.size() > 0; k++) tick();
    check("drain", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
